sm83_pch_dec_driver: RTL and testbench

Sequencer on the driving side of the SM83 precharged decode lines. It runs the precharge phase through `pch_n`, then opens one selected pulldown so that exactly one precharged node is discharged. The inverting sense cells on those nodes return a one-hot `sense` word, which the block can optionally check. One instance serves one decode group of `2**N_SEL` precharged nodes.

---
 rtl/sm83_pch_dec_driver.sv | 117 +++++++++++
 tb/tb_sm83_pch_dec_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sm83_pch_dec_driver.sv
// Precharge/evaluate sequencer for one SM83 precharged decode group.
// Optional sense checking is enabled by defining SM83_PCH_DEC_CHECK_EN.
module sm83_pch_dec_driver #(
  parameter int unsigned N_SEL    = 2,
  parameter int unsigned PCH_CYC  = 2,
  parameter int unsigned EVAL_CYC = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic [N_SEL-1:0]        sel,
  input  logic [(1<<N_SEL)-1:0]   sense,
  output logic                    pch_n,
  output logic [(1<<N_SEL)-1:0]   pd,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int unsigned LINES = 1 << N_SEL;
  localparam int unsigned CNT_W = 4;

  if (PCH_CYC < 1 || PCH_CYC > 15) begin : g_bad_pch
    $fatal(1, "PCH_CYC must be in 1..15");
  end
  if (EVAL_CYC < 1 || EVAL_CYC > 15) begin : g_bad_eval
    $fatal(1, "EVAL_CYC must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PCH,
    S_GAP,
    S_EVAL,
    S_CHECK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SEL-1:0]   sel_q, sel_d;
  logic               err_d;
  logic               mismatch;
  logic               pch_n_d;
  logic [LINES-1:0]   pd_d;
  logic               busy_d;
  logic               done_d;

`ifdef SM83_PCH_DEC_CHECK_EN
  assign mismatch = (sense != (LINES'(1) << sel_q));
`else
  logic unused_sense;
  assign unused_sense = ^sense;
  assign mismatch     = 1'b0;
`endif

  // Next state, plus outputs decoded from the next state so they leave flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_PCH;
          sel_d   = sel;
          err_d   = 1'b0;
          cnt_d   = CNT_W'(PCH_CYC - 1);
        end
      end
      S_PCH: begin
        if (cnt_q == '0) state_d = S_GAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_GAP: begin
        state_d = S_EVAL;
        cnt_d   = CNT_W'(EVAL_CYC - 1);
      end
      S_EVAL: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CHECK: begin
        state_d = S_IDLE;
        err_d   = mismatch;
      end
      default: state_d = S_IDLE;
    endcase

    pch_n_d = (state_d == S_GAP) || (state_d == S_EVAL) || (state_d == S_CHECK);
    pd_d    = (state_d == S_EVAL) ? (LINES'(1) << sel_d) : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_CHECK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      err     <= 1'b0;
      pch_n   <= 1'b0;
      pd      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err     <= err_d;
      pch_n   <= pch_n_d;
      pd      <= pd_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end
endmodule

// File: tb/tb_sm83_pch_dec_driver.sv
// Bench for sm83_pch_dec_driver: default instance plus a 15/15 timing instance,
// checked every cycle against a timeline model of the sequence.
module tb_sm83_pch_dec_driver;
  localparam int PA = 2, EA = 1, PB = 15, EB = 15;
`ifdef SM83_PCH_DEC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, req_a, req_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] sense_a, sense_b;
  logic       pch_n_a, busy_a, done_a, err_a;
  logic       pch_n_b, busy_b, done_b, err_b;
  logic [3:0] pd_a, pd_b;

  int n_vec = 0, n_miss = 0;

  // Model: t = cycles since acceptance (0 = idle), s = captured select, e = err.
  int         t_a = 0, t_b = 0;
  logic [1:0] s_a = 2'd0, s_b = 2'd0;
  logic       e_a = 1'b0, e_b = 1'b0;
  bit         armed = 1'b0;
  logic       force_a = 1'b0;
  logic [3:0] force_val = 4'd0;

  assign sense_a = force_a ? force_val : (4'b0001 << s_a);
  assign sense_b = 4'b0001 << s_b;

  sm83_pch_dec_driver #(.N_SEL(2), .PCH_CYC(PA), .EVAL_CYC(EA)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .sel(sel_a), .sense(sense_a),
    .pch_n(pch_n_a), .pd(pd_a), .busy(busy_a), .done(done_a), .err(err_a));

  sm83_pch_dec_driver #(.N_SEL(2), .PCH_CYC(PB), .EVAL_CYC(EB)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .sel(sel_b), .sense(sense_b),
    .pch_n(pch_n_b), .pd(pd_b), .busy(busy_b), .done(done_b), .err(err_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(inout int t, inout logic [1:0] s, inout logic e,
                      input int p, input int ev, input logic r,
                      input logic [1:0] si, input logic [3:0] sn);
    if (!reset_n) begin
      t = 0; s = 2'd0; e = 1'b0;
    end else if (t == 0) begin
      if (r) begin t = 1; s = si; e = 1'b0; end
    end else if (t == p + ev + 2) begin
      t = 0;
      if (CHK) e = (sn != (4'b0001 << s));
    end else begin
      t++;
    end
  endtask

  always @(posedge clk) begin
    step(t_a, s_a, e_a, PA, EA, req_a, sel_a, sense_a);
    step(t_b, s_b, e_b, PB, EB, req_b, sel_b, sense_b);
    if (!reset_n) armed = 1'b1;
  end

  task automatic cmp(input string n, input int t, input logic [1:0] s, input logic e,
                     input int p, input int ev, input logic pn, input logic [3:0] pdv,
                     input logic b, input logic d, input logic er);
    logic [3:0] pd_e;
    pd_e = (t >= p + 2 && t <= p + ev + 1) ? (4'b0001 << s) : 4'b0000;
    check({n, ".pch_n"}, 32'(pn), 32'(t > p));
    check({n, ".pd"},    32'(pdv), 32'(pd_e));
    check({n, ".busy"},  32'(b), 32'(t != 0));
    check({n, ".done"},  32'(d), 32'(t == p + ev + 2));
    check({n, ".err"},   32'(er), 32'(e));
    check({n, ".overlap"}, 32'(!pn && pdv != 4'd0), 32'd0);
    check({n, ".onehot"},  32'($onehot0(pdv)), 32'd1);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp("a", t_a, s_a, e_a, PA, EA, pch_n_a, pd_a, busy_a, done_a, err_a);
      cmp("b", t_b, s_b, e_b, PB, EB, pch_n_b, pd_b, busy_b, done_b, err_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request for one cycle; returns in cycle 1 of the sequence.
  task automatic fire_a(input logic [1:0] v);
    req_a = 1'b1;
    sel_a = v;
    tick();
    req_a = 1'b0;
  endtask

  initial begin
    int dc;
    int dcyc;
    reset_n = 1'b0; req_a = 1'b0; req_b = 1'b0; sel_a = 2'd0; sel_b = 2'd0;
    tick();
    @(negedge clk);
    check("rst.pch_n", 32'(pch_n_a), 32'd0);
    check("rst.pd",    32'(pd_a), 32'd0);
    check("rst.busy",  32'(busy_a), 32'd0);
    check("rst.done",  32'(done_a), 32'd0);
    check("rst.err",   32'(err_a), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Nominal sequence, sel=2.
    fire_a(2'd2);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) check($sformatf("nom.busy%0d", c), 32'(busy_a), 32'd1);
      if (c <= 2) check($sformatf("nom.pch%0d", c), 32'(pch_n_a), 32'd0);
      if (c == 3) check("nom.gap", 32'({pch_n_a, pd_a}), 32'({1'b1, 4'b0000}));
      if (c == 4) check("nom.pd", 32'(pd_a), 32'(4'b0100));
      check($sformatf("nom.done%0d", c), 32'(done_a), 32'(c == 5));
    end
    tick();
    @(negedge clk);
    check("nom.idle_busy", 32'(busy_a), 32'd0);

    // Sense check: good, then bad, then cleared by the next request.
    tick();
    fire_a(2'd2);
    repeat (6) tick();
    @(negedge clk);
    check("sense.good", 32'(err_a), 32'd0);
    tick();
    force_a = 1'b1; force_val = 4'b0011;
    fire_a(2'd1);
    repeat (5) tick();
    @(negedge clk);
    check("sense.bad", 32'(err_a), 32'(CHK));
    force_a = 1'b0;
    tick();
    @(negedge clk);
    check("sense.sticky", 32'(err_a), 32'(CHK));
    tick();
    fire_a(2'd3);
    @(negedge clk);
    check("sense.clear", 32'(err_a), 32'd0);
    repeat (7) tick();

    // Requests while busy are ignored.
    fire_a(2'd0);
    dc = 0;
    for (int c = 1; c <= 9; c++) begin
      req_a = (c == 1 || c == 3 || c == 4);
      sel_a = 2'd3;
      @(negedge clk);
      if (done_a) dc++;
      if (c == 4) check("busyreq.pd", 32'(pd_a), 32'(4'b0001));
      tick();
    end
    req_a = 1'b0;
    check("busyreq.ndone", 32'(dc), 32'd1);
    tick();

    // Reset during EVAL.
    fire_a(2'd1);
    repeat (3) tick();
    @(negedge clk);
    check("rstev.pd_before", 32'(pd_a), 32'(4'b0010));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rstev.outs", 32'({pd_a, pch_n_a, busy_a, done_a}), 32'd0);
    dc = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_a) dc++;
    end
    check("rstev.nodone", 32'(dc), 32'd0);
    tick();

    // Extreme timing instance with req held high.
    req_b = 1'b1; sel_b = 2'd2;
    tick();
    dcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_b && dcyc == 0) dcyc = c;
      if (c == 33) check("ext.idle_gap", 32'(busy_b), 32'd0);
      if (c == 34) check("ext.restart", 32'(busy_b), 32'd1);
      tick();
    end
    req_b = 1'b0;
    check("ext.latency", 32'(dcyc), 32'd32);

    // Randomized select and sense over 100 runs.
    for (int i = 0; i < 100; i++) begin
      force_a   = 1'($urandom_range(0, 1));
      force_val = 4'($urandom_range(0, 15));
      fire_a(2'($urandom_range(0, 3)));
      repeat (6) tick();
    end
    force_a = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
